// File: rtl/motor_pkg.sv
// Shared direction encodings, channel FSM states and command sanitising for the H-bridge controller.
// Pure definitions: no latency, no flow control.
package motor_pkg;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_FWD  = 2'b01;
    localparam logic [1:0] DIR_REV  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DEAD = 2'b01,
        ST_RUN  = 2'b10
    } h_state_e;

    // Both bridge inputs high would short the bridge, so 11 is folded into a stop.
    function automatic logic [1:0] map_cmd(input logic [1:0] cmd);
        return (cmd == 2'b11) ? DIR_STOP : cmd;
    endfunction

endpackage

// File: rtl/punte_h_ctrl_if.sv
// Command and bridge-pin bundle between the movement logic (master) and the H-bridge controller (slave).
// Wires only; commands are level-sensitive and need no handshake.
interface punte_h_ctrl_if #(
    parameter int PWM_BITS = 8
);
    logic [1:0]          directie_driverA;
    logic [1:0]          directie_driverB;
    logic [PWM_BITS-1:0] duty_max;
    logic                in1;
    logic                in2;
    logic                enA;
    logic                in3;
    logic                in4;
    logic                enB;
    logic [1:0]          dir_activA;
    logic [1:0]          dir_activB;

    modport master (
        output directie_driverA, directie_driverB, duty_max,
        input  in1, in2, enA, in3, in4, enB, dir_activA, dir_activB
    );

    modport slave (
        input  directie_driverA, directie_driverB, duty_max,
        output in1, in2, enA, in3, in4, enB, dir_activA, dir_activB
    );
endinterface

// File: rtl/punte_h_canal.sv
// One bridge channel: IDLE/DEAD/RUN FSM with dead-time counter, soft-start ramp and PWM compare.
// Outputs registered one edge after the (already registered) command; no backpressure.
module punte_h_canal
    import motor_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int DEAD_CYCLES = 1000,
    parameter int RAMP_DIV    = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          cmd_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    input  logic [PWM_BITS-1:0] duty_max_i,
    output logic [1:0]          dir_o,
    output logic                en_o
);
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam int RW = $clog2(RAMP_DIV + 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);

    h_state_e            state_q, state_d;
    logic [1:0]          dir_q, dir_d;
    logic [DW-1:0]       dead_q, dead_d;
    logic [RW-1:0]       ramp_q, ramp_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                en_q, en_d;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
        ramp_d  = ramp_q;
        duty_d  = duty_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_i == DIR_FWD || cmd_i == DIR_REV) begin
                    state_d = ST_RUN;
                    dir_d   = cmd_i;
                    duty_d  = '0;
                    ramp_d  = '0;
                end
            end
            ST_RUN: begin
                // Leaving RUN takes priority over any ramp step due on the same edge.
                if (cmd_i != dir_q) begin
                    state_d = ST_DEAD;
                    dir_d   = DIR_STOP;
                    dead_d  = '0;
                    duty_d  = '0;
                    ramp_d  = '0;
                end else begin
                    ramp_d = (ramp_q == RAMP_LAST) ? '0 : ramp_q + 1'b1;
                    if (duty_max_i < duty_q) begin
                        duty_d = duty_max_i;
                    end else if (ramp_q == RAMP_LAST && duty_q < duty_max_i) begin
                        duty_d = duty_q + 1'b1;
                    end
                end
            end
            ST_DEAD: begin
                // The exit direction is sampled only here, so glitches inside DEAD are ignored.
                if (dead_q == DEAD_LAST) begin
                    if (cmd_i == DIR_STOP) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                        dir_d   = cmd_i;
                        duty_d  = '0;
                        ramp_d  = '0;
                    end
                end else begin
                    dead_d = dead_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dir_d   = DIR_STOP;
            end
        endcase
        en_d = (state_d == ST_RUN) && (pwm_cnt_i < duty_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_STOP;
            dead_q  <= '0;
            ramp_q  <= '0;
            duty_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            dead_q  <= dead_d;
            ramp_q  <= ramp_d;
            duty_q  <= duty_d;
            en_q    <= en_d;
        end
    end

    assign dir_o = dir_q;
    assign en_o  = en_q;

endmodule

// File: rtl/punte_h_ctrl.sv
// Dual H-bridge controller: command registers, shared PWM counter and pin mapping for channels A and B.
// Command change to IN pins is two edges; no backpressure, commands are sampled every cycle.
module punte_h_ctrl
    import motor_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int DEAD_CYCLES = 1000,
    parameter int RAMP_DIV    = 256
) (
    input  logic           clk,
    input  logic           rst,
    punte_h_ctrl_if.slave  bus
);
    // Period is 2^PWM_BITS-1 so a full-scale duty keeps EN permanently high.
    localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [1:0]          cmd_a_q, cmd_b_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [1:0]          dir_a, dir_b;
    logic                en_a, en_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_a_q   <= DIR_STOP;
            cmd_b_q   <= DIR_STOP;
            pwm_cnt_q <= '0;
        end else begin
            cmd_a_q   <= map_cmd(bus.directie_driverA);
            cmd_b_q   <= map_cmd(bus.directie_driverB);
            pwm_cnt_q <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
        end
    end

    punte_h_canal #(
        .PWM_BITS    (PWM_BITS),
        .DEAD_CYCLES (DEAD_CYCLES),
        .RAMP_DIV    (RAMP_DIV)
    ) canal_a (
        .clk        (clk),
        .rst        (rst),
        .cmd_i      (cmd_a_q),
        .pwm_cnt_i  (pwm_cnt_q),
        .duty_max_i (bus.duty_max),
        .dir_o      (dir_a),
        .en_o       (en_a)
    );

    punte_h_canal #(
        .PWM_BITS    (PWM_BITS),
        .DEAD_CYCLES (DEAD_CYCLES),
        .RAMP_DIV    (RAMP_DIV)
    ) canal_b (
        .clk        (clk),
        .rst        (rst),
        .cmd_i      (cmd_b_q),
        .pwm_cnt_i  (pwm_cnt_q),
        .duty_max_i (bus.duty_max),
        .dir_o      (dir_b),
        .en_o       (en_b)
    );

    assign bus.in1        = dir_a[0];
    assign bus.in2        = dir_a[1];
    assign bus.enA        = en_a;
    assign bus.in3        = dir_b[0];
    assign bus.in4        = dir_b[1];
    assign bus.enB        = en_b;
    assign bus.dir_activA = dir_a;
    assign bus.dir_activB = dir_b;

endmodule

// File: tb/tb_punte_h_ctrl.sv
// Bench for punte_h_ctrl: timestamp-based channel model checked every cycle plus directed literal checks.
module tb_punte_h_ctrl;
    localparam int PWM_BITS = 8;
    localparam int DEAD     = 8;
    localparam int RAMP     = 4;
    localparam int PERIOD   = (1 << PWM_BITS) - 1;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    punte_h_ctrl_if #(.PWM_BITS(PWM_BITS)) bus ();

    punte_h_ctrl #(
        .PWM_BITS    (PWM_BITS),
        .DEAD_CYCLES (DEAD),
        .RAMP_DIV    (RAMP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 dead-time, 2 driving. Timing derived from edge timestamps.
    int ncyc = 0;
    int m_pwm = 0;
    int m_mode [2];
    int m_dir [2];
    int m_duty [2];
    int m_start [2];
    int m_dead_end [2];
    int m_cmdq [2];
    bit m_en [2];
    int old_pwm, mc, dm;

    always @(posedge clk) begin
        ncyc++;
        if (rst) begin
            m_pwm = 0;
            for (int ch = 0; ch < 2; ch++) begin
                m_mode[ch] = 0; m_dir[ch] = 0; m_duty[ch] = 0; m_cmdq[ch] = 0; m_en[ch] = 0;
            end
        end else begin
            old_pwm = m_pwm;
            m_pwm = (m_pwm + 1) % PERIOD;
            dm = int'(bus.duty_max);
            for (int ch = 0; ch < 2; ch++) begin
                mc = m_cmdq[ch];
                if (m_mode[ch] == 0) begin
                    if (mc == 1 || mc == 2) begin
                        m_mode[ch] = 2; m_dir[ch] = mc; m_duty[ch] = 0; m_start[ch] = ncyc;
                    end
                end else if (m_mode[ch] == 2) begin
                    if (mc != m_dir[ch]) begin
                        m_mode[ch] = 1; m_dir[ch] = 0; m_dead_end[ch] = ncyc + DEAD;
                    end else if (dm < m_duty[ch]) begin
                        m_duty[ch] = dm;
                    end else if ((ncyc - m_start[ch]) % RAMP == 0 && m_duty[ch] < dm) begin
                        m_duty[ch] = m_duty[ch] + 1;
                    end
                end else if (ncyc == m_dead_end[ch]) begin
                    if (mc == 0) m_mode[ch] = 0;
                    else begin
                        m_mode[ch] = 2; m_dir[ch] = mc; m_duty[ch] = 0; m_start[ch] = ncyc;
                    end
                end
                m_en[ch] = (m_mode[ch] == 2) && (old_pwm < m_duty[ch]);
            end
            m_cmdq[0] = (bus.directie_driverA == 2'b11) ? 0 : int'(bus.directie_driverA);
            m_cmdq[1] = (bus.directie_driverB == 2'b11) ? 0 : int'(bus.directie_driverB);
        end
    end

    logic [9:0] exp_v, got_v;
    logic [1:0] eda, edb;
    always @(negedge clk) begin
        if (ncyc > 0) begin
            eda = (m_mode[0] == 2) ? 2'(m_dir[0]) : 2'b00;
            edb = (m_mode[1] == 2) ? 2'(m_dir[1]) : 2'b00;
            exp_v = {eda[0], eda[1], m_en[0], edb[0], edb[1], m_en[1], eda, edb};
            got_v = {bus.in1, bus.in2, bus.enA, bus.in3, bus.in4, bus.enB, bus.dir_activA, bus.dir_activB};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL pins cyc=%0d got=%b expected=%b", ncyc, got_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    function automatic int a_off();
        return int'(bus.in1 === 1'b0 && bus.in2 === 1'b0 && bus.enA === 1'b0);
    endfunction

    // Counts consecutive all-low cycles on channel A, starting from the current sample.
    task automatic measure_dead(output int n);
        int g = 0;
        n = 0;
        while (a_off() == 0 && g < 10) begin @(negedge clk); g++; end
        while (a_off() == 1 && n < 30) begin n++; @(negedge clk); end
    endtask

    task automatic count_en(output int ca, output int cb);
        ca = 0; cb = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            ca += int'(bus.enA === 1'b1);
            cb += int'(bus.enB === 1'b1);
        end
    endtask

    task automatic wait_in1(input logic v, input string name);
        int g = 0;
        while (bus.in1 !== v && g < 20) begin @(negedge clk); g++; end
        check(name, int'(bus.in1 === v), 1);
    endtask

    int n, ca, cb;

    initial begin
        rst = 1'b1;
        bus.directie_driverA = 2'b01;
        bus.directie_driverB = 2'b00;
        bus.duty_max = 8'd255;
        repeat (3) @(negedge clk);
        check("reset_pins", int'({bus.in1, bus.in2, bus.enA, bus.in3, bus.in4, bus.enB,
                                   bus.dir_activA, bus.dir_activB}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("release_in1_n1", int'(bus.in1), 0);
        @(negedge clk);
        check("release_in1_n2", int'(bus.in1), 1);
        check("release_dirA", int'(bus.dir_activA), 1);

        repeat (1020) @(negedge clk);
        count_en(ca, cb);
        check("ramp_full_enA", ca, 255);
        check("ramp_B_idle_enB", cb, 0);

        bus.directie_driverB = 2'b01;
        repeat (802) @(negedge clk);
        bus.duty_max = 8'd50;
        repeat (2) @(negedge clk);
        count_en(ca, cb);
        check("clamp_enB", cb, 50);
        check("clamp_enA", ca, 50);

        bus.directie_driverA = 2'b10;
        measure_dead(n);
        check("reversal_dead_len", n, 8);
        check("reversal_pins", int'({bus.in1, bus.in2, bus.enA}), 3'b010);
        repeat (20) @(negedge clk);

        bus.directie_driverA = 2'b01;
        @(negedge clk); bus.directie_driverA = 2'b10;
        @(negedge clk); bus.directie_driverA = 2'b01;
        measure_dead(n);
        check("glitch_dead_len", n, 8);
        check("glitch_dirA", int'(bus.dir_activA), 1);
        repeat (20) @(negedge clk);

        bus.directie_driverA = 2'b11;
        measure_dead(n);
        check("invalid_to_idle", n, 30);
        check("invalid_dirA", int'(bus.dir_activA), 0);

        bus.directie_driverA = 2'b01;
        wait_in1(1'b1, "restart_in1");
        repeat (10) @(negedge clk);
        bus.directie_driverA = 2'b11;
        wait_in1(1'b0, "dead_entry");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus.directie_driverA = 2'b01;
        @(negedge clk);
        check("midreset_pins", int'({bus.in1, bus.in2, bus.enA, bus.in3, bus.in4, bus.enB,
                                      bus.dir_activA, bus.dir_activB}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("postreset_in1_n1", int'(bus.in1), 0);
        @(negedge clk);
        check("postreset_in1_n2", int'(bus.in1), 1);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
